// File: rtl/fp_div.sv
// Sequential restoring floating-point divider, op3 = op1 / op2, one quotient bit per clock.
// state | meaning
// IDLE  | waiting for operands, in_ready high
// DIV   | restoring division, one quotient bit per edge
// NORM  | normalise quotient, form exponent, range check
// DONE  | result held until out_ready
module fp_div #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op1_sign,
    input  logic [EXP_WIDTH-1:0]  op1_exp,
    input  logic [FRAC_WIDTH-1:0] op1_frac,
    input  logic                  op2_sign,
    input  logic [EXP_WIDTH-1:0]  op2_exp,
    input  logic [FRAC_WIDTH-1:0] op2_frac,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  op3_sign,
    output logic [EXP_WIDTH-1:0]  op3_exp,
    output logic [FRAC_WIDTH-1:0] op3_frac,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  div_by_zero
);
    localparam int MW = FRAC_WIDTH + 1;
    localparam int QW = FRAC_WIDTH + 2;
    localparam int EW = EXP_WIDTH + 2;
    localparam int CW = $clog2(FRAC_WIDTH + 2);
    localparam logic [EW-1:0] BIAS      = EW'((1 << (EXP_WIDTH - 1)) - 1);
    localparam logic [EW-1:0] EXP_MAX   = EW'((1 << EXP_WIDTH) - 1);
    localparam logic [CW-1:0] ITER_LAST = CW'(FRAC_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
    state_t state_q, state_d;

    logic [QW-1:0]         rem_q;
    logic [QW-1:0]         quot_q;
    logic [MW-1:0]         divisor_q;
    logic [CW-1:0]         cnt_q;
    logic [EW-1:0]         exp_base_q;

    logic                  op1_zero, op2_zero;
    logic                  rem_ge;
    logic [QW-1:0]         rem_shift;
    logic                  norm_adj;
    logic [FRAC_WIDTH-1:0] norm_frac;
    logic [EW-1:0]         exp_norm;
    logic                  exp_ovf, exp_unf;

    assign op1_zero  = (op1_exp == '0) && (op1_frac == '0);
    assign op2_zero  = (op2_exp == '0) && (op2_frac == '0);
    assign rem_ge    = rem_q >= {1'b0, divisor_q};
    assign rem_shift = (rem_ge ? rem_q - {1'b0, divisor_q} : rem_q) << 1;

    // Quotient lies in (0.5, 2): either the integer bit or the next one is the leading 1.
    assign norm_adj  = ~quot_q[QW-1];
    assign norm_frac = quot_q[QW-1] ? quot_q[FRAC_WIDTH:1] : quot_q[FRAC_WIDTH-1:0];
    assign exp_norm  = exp_base_q - {{(EW-1){1'b0}}, norm_adj};
    assign exp_ovf   = !exp_norm[EW-1] && (exp_norm >= EXP_MAX);
    assign exp_unf   = exp_norm[EW-1] || (exp_norm == '0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = (op1_zero || op2_zero) ? DONE : DIV;
            end
            DIV:  if (cnt_q == '0) state_d = NORM;
            NORM: state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q       <= '0;
            quot_q      <= '0;
            divisor_q   <= '0;
            cnt_q       <= '0;
            exp_base_q  <= '0;
            op3_sign    <= 1'b0;
            op3_exp     <= '0;
            op3_frac    <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    rem_q       <= {1'b0, 1'b1, op1_frac};
                    divisor_q   <= {1'b1, op2_frac};
                    quot_q      <= '0;
                    cnt_q       <= ITER_LAST;
                    exp_base_q  <= {2'b00, op1_exp} - {2'b00, op2_exp} + BIAS;
                    op3_sign    <= op1_sign ^ op2_sign;
                    op3_exp     <= '0;
                    op3_frac    <= '0;
                    overflow    <= 1'b0;
                    underflow   <= 1'b0;
                    div_by_zero <= 1'b0;
                    if (op2_zero) begin
                        op3_exp     <= '1;
                        op3_frac    <= op1_zero ? '1 : '0;
                        div_by_zero <= 1'b1;
                    end
                end
                DIV: begin
                    rem_q  <= rem_shift;
                    quot_q <= {quot_q[QW-2:0], rem_ge};
                    cnt_q  <= cnt_q - CW'(1);
                end
                NORM: begin
                    if (exp_ovf) begin
                        op3_exp  <= '1;
                        overflow <= 1'b1;
                    end else if (exp_unf) begin
                        underflow <= 1'b1;
                    end else begin
                        op3_exp  <= exp_norm[EXP_WIDTH-1:0];
                        op3_frac <= norm_frac;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed cases, specials, random operands, backpressure, mid-op reset.
module tb_fp_div;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op1_sign = 1'b0;
    logic [7:0]  op1_exp = '0;
    logic [6:0]  op1_frac = '0;
    logic        op2_sign = 1'b0;
    logic [7:0]  op2_exp = '0;
    logic [6:0]  op2_frac = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        op3_sign;
    logic [7:0]  op3_exp;
    logic [6:0]  op3_frac;
    logic        overflow, underflow, div_by_zero;
    logic [18:0] got;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_div #(.EXP_WIDTH(8), .FRAC_WIDTH(7)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op1_sign(op1_sign), .op1_exp(op1_exp), .op1_frac(op1_frac),
        .op2_sign(op2_sign), .op2_exp(op2_exp), .op2_frac(op2_frac),
        .out_valid(out_valid), .out_ready(out_ready),
        .op3_sign(op3_sign), .op3_exp(op3_exp), .op3_frac(op3_frac),
        .overflow(overflow), .underflow(underflow), .div_by_zero(div_by_zero)
    );

    assign got = {op3_sign, op3_exp, op3_frac, overflow, underflow, div_by_zero};

    // operand = {sign, exp, frac}; result = {sign, exp, frac, ovf, unf, dbz}
    localparam int ND = 10;
    localparam logic [15:0] D_OP1 [ND] = '{
        {1'b0, 8'd129, 7'h40}, {1'b0, 8'd127, 7'h00}, {1'b1, 8'd129, 7'h00},
        {1'b0, 8'd254, 7'h00}, {1'b0, 8'd1,   7'h00}, {1'b0, 8'd2,   7'h00},
        {1'b0, 8'd0,   7'h00}, {1'b0, 8'd129, 7'h60}, {1'b0, 8'd0,   7'h00},
        {1'b1, 8'd0,   7'h00}};
    localparam logic [15:0] D_OP2 [ND] = '{
        {1'b0, 8'd128, 7'h00}, {1'b0, 8'd128, 7'h40}, {1'b0, 8'd126, 7'h00},
        {1'b0, 8'd1,   7'h00}, {1'b0, 8'd254, 7'h00}, {1'b0, 8'd128, 7'h00},
        {1'b0, 8'd129, 7'h20}, {1'b0, 8'd0,   7'h00}, {1'b0, 8'd0,   7'h00},
        {1'b0, 8'd129, 7'h20}};
    localparam logic [18:0] D_RES [ND] = '{
        {1'b0, 8'd128, 7'h40, 3'b000}, {1'b0, 8'd125, 7'h2A, 3'b000},
        {1'b1, 8'd130, 7'h00, 3'b000}, {1'b0, 8'd255, 7'h00, 3'b100},
        {1'b0, 8'd0,   7'h00, 3'b010}, {1'b0, 8'd1,   7'h00, 3'b000},
        {1'b0, 8'd0,   7'h00, 3'b000}, {1'b0, 8'd255, 7'h00, 3'b001},
        {1'b0, 8'd255, 7'h7F, 3'b001}, {1'b1, 8'd0,   7'h00, 3'b000}};
    // edges after the accepting edge until out_valid is seen high
    localparam int D_LAT [ND] = '{10, 10, 10, 10, 10, 10, 0, 0, 0, 0};

    // Reference: quotient of the significands as an integer ratio, exponent from plain arithmetic.
    task automatic model(input logic [15:0] a, input logic [15:0] b,
                         output logic [18:0] ev, output int el);
        bit z1, z2, ovf, unf, dbz;
        int sa, sb, q, fr, adj, ee;
        logic [7:0] re;
        logic [6:0] rf;
        z1 = (a[14:0] == 15'd0);
        z2 = (b[14:0] == 15'd0);
        ovf = 0; unf = 0; dbz = 0; re = 8'd0; rf = 7'd0;
        if (z2) begin
            re = 8'hFF; rf = z1 ? 7'h7F : 7'h00; dbz = 1; el = 0;
        end else if (z1) begin
            el = 0;
        end else begin
            sa = 128 + int'(a[6:0]);
            sb = 128 + int'(b[6:0]);
            q = (sa * 256) / sb;
            if (q >= 256) begin fr = (q / 2) % 128; adj = 0; end
            else          begin fr = q % 128;       adj = 1; end
            ee = int'(a[14:7]) - int'(b[14:7]) + 127 - adj;
            if (ee >= 255)    begin re = 8'hFF; ovf = 1; end
            else if (ee <= 0) unf = 1;
            else begin re = 8'(ee); rf = 7'(fr); end
            el = 10;
        end
        ev = {a[15] ^ b[15], re, rf, ovf, unf, dbz};
    endtask

    // Launch one operation; noisy in_valid/operands while busy must be ignored.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic consume, output int lat);
        @(negedge clk);
        {op1_sign, op1_exp, op1_frac} = a;
        {op2_sign, op2_exp, op2_frac} = b;
        out_ready = consume;
        in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!out_valid && lat < 40) begin
            in_valid = 1'($urandom_range(0, 1));
            {op1_sign, op1_exp, op1_frac} = 16'($urandom);
            {op2_sign, op2_exp, op2_frac} = 16'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) lat = -1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++; $display("FAIL reset_handshake got=%b want=10", {in_ready, out_valid});
        end
        checks++;
        if (got !== 19'd0) begin
            errors++; $display("FAIL reset_outputs got=%h want=0", got);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0] a, b;
        logic [18:0] r;
        int lat;
        for (int i = 0; i < ND; i++) begin
            a = D_OP1[i]; b = D_OP2[i]; r = D_RES[i];
            run_op(a, b, 1'b1, lat);
            checks++;
            if (lat !== D_LAT[i]) begin
                errors++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, D_LAT[i]);
            end
            checks++;
            if (got !== r) begin
                errors++; $display("FAIL directed_result[%0d] got=%h want=%h", i, got, r);
            end
            drain();
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic [18:0] ev;
        int el, lat;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 7) == 0) a[14:0] = 15'd0;
            if ($urandom_range(0, 7) == 0) b[14:0] = 15'd0;
            model(a, b, ev, el);
            run_op(a, b, 1'b1, lat);
            checks++;
            if (lat !== el) begin
                errors++; $display("FAIL random_latency a=%h b=%h got=%0d want=%0d", a, b, lat, el);
            end
            checks++;
            if (got !== ev) begin
                errors++; $display("FAIL random_result a=%h b=%h got=%h want=%h", a, b, got, ev);
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] a, b;
        logic [18:0] ev, snap;
        int el, lat;
        a = {1'b0, 8'd129, 7'h40}; b = {1'b0, 8'd128, 7'h00};
        model(a, b, ev, el);
        run_op(a, b, 1'b0, lat);
        checks++;
        if (got !== ev || lat !== el) begin
            errors++; $display("FAIL bp_first got=%h lat=%0d want=%h lat=%0d", got, lat, ev, el);
        end
        snap = ev;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            {op1_sign, op1_exp, op1_frac} = 16'($urandom);
            {op2_sign, op2_exp, op2_frac} = 16'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, got} !== {2'b10, snap}) begin
                errors++; $display("FAIL bp_hold[%0d] got=%b_%h want=10_%h", i, {out_valid, in_ready}, got, snap);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_release got=%b want=01", {out_valid, in_ready});
        end
        in_valid = 1'b0;
        a = {1'b0, 8'd127, 7'h00}; b = {1'b0, 8'd128, 7'h40};
        model(a, b, ev, el);
        run_op(a, b, 1'b1, lat);
        checks++;
        if (got !== ev || lat !== el) begin
            errors++; $display("FAIL bp_next got=%h lat=%0d want=%h lat=%0d", got, lat, ev, el);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic [15:0] a, b;
        logic [18:0] ev;
        int el, lat;
        bit seen;
        a = {1'b0, 8'd129, 7'h40}; b = {1'b0, 8'd128, 7'h00};
        @(negedge clk);
        {op1_sign, op1_exp, op1_frac} = a;
        {op2_sign, op2_exp, op2_frac} = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid, got} !== {2'b10, 19'd0}) begin
            errors++; $display("FAIL midreset_state got=%b_%h want=10_0", {in_ready, out_valid}, got);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL midreset_no_output got=%b want=0", seen);
        end
        model(a, b, ev, el);
        run_op(a, b, 1'b1, lat);
        checks++;
        if (got !== ev || lat !== el) begin
            errors++; $display("FAIL midreset_fresh got=%h lat=%0d want=%h lat=%0d", got, lat, ev, el);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
